// File: rtl/onchip_mem_pkg.sv
// Shared constants, state encoding and read-tag type for the on-chip RAM arbiter.
package onchip_mem_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 62500;
  localparam int MAX_BURST = 16;
  localparam int BCNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RBURST = 2'd1,
    WBURST = 2'd2
  } state_e;

  // One entry per issued read beat, consumed on the following cycle.
  typedef struct packed {
    logic valid;
    logic owner;
    logic oor;
  } rd_tag_t;

  // Beats actually performed for a requested burstcount: 0 means 1, and
  // anything above MAX_BURST is clamped so the counter cannot overrun.
  function automatic logic [BCNT_W-1:0] beats_of(input logic [BCNT_W-1:0] bc);
    if (bc == 5'd0) begin
      return 5'd1;
    end else if (bc > 5'(MAX_BURST)) begin
      return 5'(MAX_BURST);
    end else begin
      return bc;
    end
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the last winner loses the next tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       gnt_valid_o,
  output logic       gnt_o
);

  logic last_q;

  // Pick a winner from the current requests, favouring the master that did not win last.
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_o       = 1'b0;
    case (req_i)
      2'b01:   gnt_o = 1'b0;
      2'b10:   gnt_o = 1'b1;
      2'b11:   gnt_o = ~last_q;
      default: gnt_o = 1'b0;
    endcase
  end

  // Remember the winner whenever a grant is actually taken; reset favours m0.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (update_i && gnt_valid_o) begin
      last_q <= gnt_o;
    end else begin
      last_q <= last_q;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Burst-granular round-robin sharing of the single-port on-chip RAM between
// the CPU data master (m0) and the light-pattern refresh engine (m1).
module onchip_mem_arbiter
  import onchip_mem_pkg::*;
#(
  parameter int P_ADDR_W = ADDR_W,
  parameter int P_DATA_W = DATA_W,
  parameter int P_DEPTH  = DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [P_ADDR_W-1:0]   m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [BCNT_W-1:0]     m0_burstcount,
  input  logic [P_DATA_W/8-1:0] m0_byteenable,
  input  logic [P_DATA_W-1:0]   m0_writedata,
  output logic                  m0_waitrequest,
  output logic [P_DATA_W-1:0]   m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [P_ADDR_W-1:0]   m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [BCNT_W-1:0]     m1_burstcount,
  input  logic [P_DATA_W/8-1:0] m1_byteenable,
  input  logic [P_DATA_W-1:0]   m1_writedata,
  output logic                  m1_waitrequest,
  output logic [P_DATA_W-1:0]   m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [P_ADDR_W-1:0]   mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [P_DATA_W/8-1:0] mem_byteenable,
  output logic [P_DATA_W-1:0]   mem_writedata,
  output logic                  mem_clken,
  input  logic [P_DATA_W-1:0]   mem_readdata,
  output logic                  err_oor
);

  localparam logic [P_ADDR_W:0] DEPTH_L = (P_ADDR_W+1)'(P_DEPTH);

  state_e                state_q;
  logic                  owner_q;
  logic [BCNT_W-1:0]     remain_q;
  logic [P_ADDR_W-1:0]   next_addr_q;
  rd_tag_t               tag_q;
  logic                  err_q;

  logic [1:0]            req_s;
  logic                  gnt_valid_s;
  logic                  gnt_s;
  logic                  arb_update_s;
  logic                  own_s;
  logic                  own_wr_s;
  logic                  issue_s;
  logic                  issue_wr_s;
  logic                  beat_oor_s;
  logic [P_ADDR_W-1:0]   beat_addr_s;
  logic [P_DATA_W/8-1:0] beat_be_s;
  logic [P_DATA_W-1:0]   beat_wd_s;
  logic [BCNT_W-1:0]     first_n_s;
  logic                  m0_wait_s;
  logic                  m1_wait_s;
  rd_tag_t               tag_d_s;

  assign req_s        = {m1_read | m1_write, m0_read | m0_write};
  assign arb_update_s = (state_q == IDLE);

  rr_arb2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_s),
    .update_i    (arb_update_s),
    .gnt_valid_o (gnt_valid_s),
    .gnt_o       (gnt_s)
  );

  // Decide which beat (if any) reaches the RAM this cycle and who gets waitrequest low.
  always_comb begin
    own_s       = owner_q;
    own_wr_s    = owner_q ? m1_write : m0_write;
    issue_s     = 1'b0;
    issue_wr_s  = 1'b0;
    beat_addr_s = next_addr_q;
    beat_be_s   = '1;
    beat_wd_s   = '0;
    first_n_s   = 5'd1;
    m0_wait_s   = 1'b1;
    m1_wait_s   = 1'b1;
    case (state_q)
      IDLE: begin
        own_s = gnt_s;
        if (gnt_valid_s) begin
          issue_s = 1'b1;
          if (gnt_s) begin
            beat_addr_s = m1_address;
            issue_wr_s  = m1_write;
            beat_be_s   = m1_byteenable;
            beat_wd_s   = m1_writedata;
            first_n_s   = beats_of(m1_burstcount);
            m1_wait_s   = 1'b0;
          end else begin
            beat_addr_s = m0_address;
            issue_wr_s  = m0_write;
            beat_be_s   = m0_byteenable;
            beat_wd_s   = m0_writedata;
            first_n_s   = beats_of(m0_burstcount);
            m0_wait_s   = 1'b0;
          end
        end else begin
          issue_s = 1'b0;
        end
      end
      RBURST: begin
        issue_s = 1'b1;
      end
      WBURST: begin
        if (own_wr_s) begin
          issue_s    = 1'b1;
          issue_wr_s = 1'b1;
          beat_be_s  = owner_q ? m1_byteenable : m0_byteenable;
          beat_wd_s  = owner_q ? m1_writedata : m0_writedata;
          if (owner_q) begin
            m1_wait_s = 1'b0;
          end else begin
            m0_wait_s = 1'b0;
          end
        end else begin
          issue_s = 1'b0;
        end
      end
      default: begin
        issue_s = 1'b0;
      end
    endcase
    beat_oor_s    = ({1'b0, beat_addr_s} >= DEPTH_L);
    tag_d_s.valid = issue_s & ~issue_wr_s;
    tag_d_s.owner = own_s;
    tag_d_s.oor   = beat_oor_s;
  end

  // Burst FSM, beat counter/address, read-return tag and sticky out-of-range flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      remain_q    <= 5'd0;
      next_addr_q <= '0;
      tag_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      tag_q <= tag_d_s;
      if (issue_s && beat_oor_s) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (gnt_valid_s) begin
            owner_q     <= gnt_s;
            next_addr_q <= beat_addr_s + P_ADDR_W'(1);
            remain_q    <= first_n_s - 5'd1;
            if (first_n_s > 5'd1) begin
              state_q <= issue_wr_s ? WBURST : RBURST;
            end
          end
        end
        RBURST, WBURST: begin
          if (issue_s) begin
            next_addr_q <= next_addr_q + P_ADDR_W'(1);
            remain_q    <= remain_q - 5'd1;
            if (remain_q == 5'd1) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_address      = beat_addr_s;
  assign mem_chipselect   = issue_s & ~beat_oor_s;
  assign mem_write        = issue_s & issue_wr_s & ~beat_oor_s;
  assign mem_byteenable   = beat_be_s;
  assign mem_writedata    = beat_wd_s;
  assign mem_clken        = 1'b1;
  assign m0_waitrequest   = m0_wait_s;
  assign m1_waitrequest   = m1_wait_s;
  assign m0_readdatavalid = tag_q.valid & ~tag_q.owner;
  assign m1_readdatavalid = tag_q.valid & tag_q.owner;
  assign m0_readdata      = tag_q.oor ? '0 : mem_readdata;
  assign m1_readdata      = tag_q.oor ? '0 : mem_readdata;
  assign err_oor          = err_q;

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Shares the single-port 32-bit on-chip RAM (62500 words, byteenable, 1-cycle read latency) between two Avalon-MM-style requesters.
  - m0: CPU data master.
  - m1: light-pattern refresh engine.
- Round-robin arbitration at burst granularity. Generates beat addresses internally.
- Routes read data back to the owner and drops out-of-range accesses.
- Sits between the interconnect masters and the RAM's s1 slave.

Parameters:
- ADDR_W, 16, word-address width.
- DATA_W, 32, data width (byteenable width = DATA_W/8).
- DEPTH, 62500, number of valid words; addresses >= DEPTH are out of range.
- MAX_BURST, 16, maximum beats per burst.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- mN_address (N=0,1), in, ADDR_W, start word address.
- mN_read / mN_write, in, 1, command strobes; both high = write.
- mN_burstcount, in, 5, beats 1..MAX_BURST; 0 is treated as 1.
- mN_byteenable, in, DATA_W/8, per-beat byte enables.
- mN_writedata, in, DATA_W, per-beat write data.
- mN_waitrequest, out, 1, high = command/beat not accepted this cycle.
- mN_readdata, out, DATA_W, read data.
- mN_readdatavalid, out, 1, one pulse per read beat.
- mem_address, out, ADDR_W, to RAM.
- mem_chipselect, out, 1, to RAM.
- mem_write, out, 1, to RAM.
- mem_byteenable, out, DATA_W/8, to RAM.
- mem_writedata, out, DATA_W, to RAM.
- mem_clken, out, 1, tied high.
- mem_readdata, in, DATA_W, RAM output, valid 1 cycle after address.
- err_oor, out, 1, sticky; set on any out-of-range beat, cleared only by reset.

Behaviour:
- Reset (takes effect at the next clk edge):
  - FSM=IDLE, last_grant=1 (m0 wins the first tie), beat counter=0.
  - rd tag pipeline empty.
  - All readdatavalid=0, mem_chipselect=0, mem_write=0, err_oor=0, waitrequest=1 for both masters.
- Reset mid-burst: burst abandoned; in-flight readdatavalid suppressed on the following cycle.
- FSM states: IDLE, RBURST, WBURST.
- IDLE:
  - Requesters = masters with read|write high.
  - Both requesting: grant the master != last_grant. One requesting: grant it.
  - Grant is combinational in the same cycle.
  - Granted master's first beat is issued to the RAM this cycle; its waitrequest=0. Loser's waitrequest=1.
  - last_grant updated to the winner.
  - n = max(burstcount, 1).
  - n=1: stay IDLE. Otherwise go to RBURST/WBURST with remaining = n-1 and next_addr = address+1.
- RBURST:
  - Arbiter drives mem_address=next_addr, chipselect=1, write=0, one beat per cycle.
  - Owner's waitrequest=1 (command already accepted).
  - next_addr increments and remaining decrements each cycle; remaining reaching 0 → IDLE.
  - A new grant is possible in the same cycle the last beat issues only from IDLE, i.e. the next cycle.
- WBURST:
  - Each cycle the owner holds write high, owner waitrequest=0 and beat = writedata/byteenable at next_addr.
  - If the owner deasserts write: no beat issued, no count change (wait state).
  - Other master waitrequest=1 for the whole burst.
- Read return:
  - Every issued read beat pushes {valid, owner, oor} into a 1-deep registered tag.
  - Next cycle: owner readdatavalid=1 with readdata=mem_readdata, or 0 if the beat was oor.
  - Non-owner readdata is don't-care with valid=0.
- Out of range (beat address >= DEPTH):
  - Write beat: chipselect=0, RAM not written, still counted as accepted.
  - Read beat: chipselect=0, returns 0 with valid.
  - Either case sets err_oor.
  - Address increment is ADDR_W-bit and wraps at 2^ADDR_W; no wrap at DEPTH.
- Throughput: one beat per cycle; back-to-back bursts alternate masters under contention.
- Read latency: command cycle + 1.

Decomposition:
- Package onchip_mem_pkg holds:
  - Constants: ADDR_W, DATA_W, DEPTH, MAX_BURST.
  - State enum: IDLE/RBURST/WBURST.
  - Struct rd_tag_t {valid, owner, oor}.
- One sub-module, rr_arb2: 2-way round-robin grant with a last_grant register and an update-enable input.

Test Plan:
- Single m0 read at addr 0x0010 (RAM word = 0xDEADBEEF) → m0_waitrequest low in cycle T, m0_readdatavalid high in T+1 with data 0xDEADBEEF.
- m0 and m1 both request single reads from reset → m0 granted at T, m1 at T+1, m0 again at T+2 if still requesting; valids return in the same order.
- m1 read burst of 4 from 0x0100 → mem_address 0x100..0x103 on 4 consecutive cycles, 4 valid pulses, m0 stalled with waitrequest=1 for those 4 cycles.
- m0 write burst of 3 at 0x0200 with write dropped for 1 cycle after beat 1 → RAM writes 0x200, 0x201, 0x202 only on cycles with write high, total 4 cycles; readback matches.
- m0 burst of 4 reads from 62498 → beats at 62498 and 62499 return RAM data, 62500 and 62501 return 0 with valid, mem_chipselect=0 on those beats, err_oor=1 until reset.
- Reset asserted during the 2nd beat of a 4-beat m1 read → no further beats issued, no readdatavalid after the reset cycle, both waitrequest=1, next grant goes to m0.
